// File: rtl/async_transmitter.sv
// async_transmitter
//   UART transmitter with 8N1 framing. It sends bytes from a small holding FIFO
//   onto TxD at a fixed baud rate. Frames go out back-to-back: the start bit of
//   the next frame follows the stop bit immediately, with no idle bit between.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   -> 8E1 frames (even parity bit between data bit 7 and stop)
//     undefined -> 8N1 frames, with no parity state or parity logic
//
// Parameters
//   ClkFrequency  clk frequency in Hz
//   Baud          line rate in bits/s
//   FifoDepth     holding FIFO entries; must be a power of 2 and at least 2
//
// Ports
//   clk        in   clock
//   rst_n      in   synchronous, active-low reset
//   TxD_start  in   write strobe; the byte is accepted on a clock edge where
//                   TxD_start && TxD_ready
//   TxD_data   in   byte to queue; sampled together with TxD_start
//   TxD_ready  out  FIFO not full
//   TxD        out  serial line, registered, idle high
//   TxD_busy   out  FIFO non-empty or frame in progress
module async_transmitter #(
   parameter int ClkFrequency = 25000000,
   parameter int Baud         = 115200,
   parameter int FifoDepth    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       TxD_start,
   input  logic [7:0] TxD_data,
   output logic       TxD_ready,
   output logic       TxD,
   output logic       TxD_busy
);

   localparam int BIT_CYCLES = (ClkFrequency + Baud/2) / Baud;
   localparam int TW         = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
   localparam int AW         = (FifoDepth > 2) ? $clog2(FifoDepth) : 1;
   localparam int CW         = AW + 1;

   localparam logic [TW-1:0] TIMER_LAST = TW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] FIFO_FULL  = CW'(FifoDepth);

   generate
      if (BIT_CYCLES < 2) begin : g_bad_baud
         $error("async_transmitter: BIT_CYCLES must be at least 2");
      end
      if ((FifoDepth < 2) || ((FifoDepth & (FifoDepth - 1)) != 0)) begin : g_bad_depth
         $error("async_transmitter: FifoDepth must be a power of 2 and at least 2");
      end
   endgenerate

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd4;
`endif

   // ---------------------------------------------------------------- FIFO
   logic [7:0]    r_mem [FifoDepth];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;

   logic          w_push;
   logic          w_pop;
   logic          w_nonempty;
   logic [7:0]    w_pop_data;

   // ----------------------------------------------------------------- FSM
   logic [2:0]    r_state;
   logic [TW-1:0] r_timer;
   logic [7:0]    r_shift;
   logic [2:0]    r_bitidx;
   logic          r_txd;
`ifdef UART_TX_PARITY_EN
   logic          r_parity;
`endif

   logic          w_bit_end;

   assign w_nonempty = (r_count != '0);
   assign w_bit_end  = (r_timer == TIMER_LAST);
   assign w_pop_data = r_mem[r_rptr];

   // A push is judged only against the registered count. This means a full
   // FIFO rejects a push even when a pop happens on the same edge.
   assign w_push = TxD_start && TxD_ready;

   // Pop from IDLE, or at the end of the stop bit so the next start bit
   // follows without a gap.
   assign w_pop  = w_nonempty &&
                   ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= TxD_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // TxD is registered and follows the next state, so the line value is
   // already correct on the edge that enters each state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_timer  <= '0;
         r_shift  <= '0;
         r_bitidx <= '0;
         r_txd    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_parity <= 1'b0;
`endif
      end else begin
         // In IDLE the timer is held at zero. Every other state changes
         // only on w_bit_end, so the timer restarts on each state entry.
         if ((r_state == S_IDLE) || w_bit_end) begin
            r_timer <= '0;
         end else begin
            r_timer <= r_timer + 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_shift  <= w_pop_data;
`ifdef UART_TX_PARITY_EN
                  r_parity <= ^w_pop_data;
`endif
                  r_state  <= S_START;
                  r_txd    <= 1'b0;
               end else begin
                  r_txd    <= 1'b1;
               end
            end

            S_START: begin
               if (w_bit_end) begin
                  r_state  <= S_DATA;
                  r_bitidx <= '0;
                  r_txd    <= r_shift[0];
               end
            end

            S_DATA: begin
               if (w_bit_end) begin
                  r_shift  <= r_shift >> 1;
                  r_bitidx <= r_bitidx + 1'b1;
                  if (r_bitidx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     r_state <= S_PARITY;
                     r_txd   <= r_parity;
`else
                     r_state <= S_STOP;
                     r_txd   <= 1'b1;
`endif
                  end else begin
                     r_txd   <= r_shift[1];
                  end
               end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (w_bit_end) begin
                  r_state <= S_STOP;
                  r_txd   <= 1'b1;
               end
            end
`endif

            S_STOP: begin
               if (w_bit_end) begin
                  if (w_pop) begin
                     r_shift  <= w_pop_data;
`ifdef UART_TX_PARITY_EN
                     r_parity <= ^w_pop_data;
`endif
                     r_state  <= S_START;
                     r_txd    <= 1'b0;
                  end else begin
                     r_state  <= S_IDLE;
                     r_txd    <= 1'b1;
                  end
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_txd   <= 1'b1;
            end
         endcase
      end
   end

   assign TxD       = r_txd;
   assign TxD_ready = (r_count != FIFO_FULL);
   assign TxD_busy  = (r_state != S_IDLE) || w_nonempty;

endmodule

// File: tb/tb_async_transmitter.sv
// tb_async_transmitter
//   Self-checking bench for async_transmitter. Stimulus runs through directed
//   scenarios and then random bursts. A queue-based line model predicts the
//   values of TxD, TxD_busy and TxD_ready after every clock edge.
module tb_async_transmitter;

   localparam int CLK_HZ = 800000;
   localparam int BAUD   = 100000;
   localparam int DEPTH  = 4;
   localparam int BC     = (CLK_HZ + BAUD/2) / BAUD;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS  = 11;
`else
   localparam int NBITS  = 10;
`endif
   localparam int FRAME  = NBITS * BC;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       TxD_start = 1'b0;
   logic [7:0] TxD_data = 8'h00;
   logic       TxD_ready;
   logic       TxD;
   logic       TxD_busy;

   always #5 clk = ~clk;

   async_transmitter #(
      .ClkFrequency (CLK_HZ),
      .Baud         (BAUD),
      .FifoDepth    (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .TxD_start (TxD_start),
      .TxD_data  (TxD_data),
      .TxD_ready (TxD_ready),
      .TxD       (TxD),
      .TxD_busy  (TxD_busy)
   );

   // Reference model: queued bytes, plus the per-clock line values still to
   // be driven for the frame in flight.
   logic [7:0] m_fifo[$];
   bit         m_line[$];
   logic       exp_txd   = 1'b1;
   logic       exp_busy  = 1'b0;
   logic       exp_ready = 1'b1;

   int compared   = 0;
   int mismatched = 0;

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic add_bit(input bit v);
      for (int k = 0; k < BC; k++) m_line.push_back(v);
   endtask

   task automatic load_frame(input logic [7:0] b);
      add_bit(1'b0);
      for (int i = 0; i < 8; i++) add_bit(b[i]);
`ifdef UART_TX_PARITY_EN
      add_bit(^b);
`endif
      add_bit(1'b1);
   endtask

   // One clock: advance the model using the inputs held across the edge,
   // then compare all outputs 1 time unit later.
   task automatic step();
      bit accept;
      bit active;
      @(posedge clk);
      if (!rst_n) begin
         m_fifo.delete();
         m_line.delete();
         exp_txd   = 1'b1;
         exp_busy  = 1'b0;
         exp_ready = 1'b1;
      end else begin
         accept = TxD_start && (m_fifo.size() < DEPTH);
         if ((m_line.size() == 0) && (m_fifo.size() != 0)) load_frame(m_fifo.pop_front());
         if (accept) m_fifo.push_back(TxD_data);
         active = (m_line.size() != 0);
         exp_txd   = active ? m_line.pop_front() : 1'b1;
         exp_busy  = active || (m_fifo.size() != 0);
         exp_ready = (m_fifo.size() != DEPTH);
      end
      #1;
      check_bit("txd", TxD, exp_txd);
      check_bit("busy", TxD_busy, exp_busy);
      check_bit("ready", TxD_ready, exp_ready);
   endtask

   task automatic run_until_idle();
      int n;
      n = 0;
      while (((m_line.size() != 0) || (m_fifo.size() != 0)) && (n < 3000)) begin
         step();
         n++;
      end
      if (n >= 3000) check_int("idle_timeout", n, 0);
      step();
      step();
   endtask

   initial begin
      int busy_cnt;
      int acc;

      // Reset values
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;

      // Idle line after reset
      repeat (1000) step();

      // Single byte 0x55: count busy clocks from the push edge
      busy_cnt  = 0;
      TxD_start = 1'b1;
      TxD_data  = 8'h55;
      step();
      if (TxD_busy) busy_cnt++;
      TxD_start = 1'b0;
      repeat (FRAME + 40) begin
         step();
         if (TxD_busy) busy_cnt++;
      end
      check_int("single_busy_len", busy_cnt, FRAME + 1);

      // Odd parity data byte (parity bit 1 in the parity build)
      TxD_start = 1'b1;
      TxD_data  = 8'h07;
      step();
      TxD_start = 1'b0;
      run_until_idle();

      // Burst: hold start for 6 cycles, 0x11..0x16
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         TxD_start = 1'b1;
         TxD_data  = 8'(8'h11 + i);
         if (TxD_ready) acc++;
         step();
      end
      TxD_start = 1'b0;
      check_int("burst_accepted", acc, 5);
      run_until_idle();

      // Push during transmission
      TxD_start = 1'b1;
      TxD_data  = 8'h3C;
      step();
      TxD_start = 1'b0;
      repeat (30) step();
      TxD_start = 1'b1;
      TxD_data  = 8'hA3;
      step();
      TxD_start = 1'b0;
      run_until_idle();

      // Reset mid-frame during bit 4 of 0xF0 with two bytes queued
      TxD_start = 1'b1;
      TxD_data  = 8'hF0;
      step();
      TxD_data  = 8'h81;
      step();
      TxD_data  = 8'h82;
      step();
      TxD_start = 1'b0;
      repeat (41) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (200) step();

      // Random bursts
      for (int r = 0; r < 20; r++) begin
         repeat ($urandom_range(40, 0)) step();
         repeat ($urandom_range(6, 1)) begin
            TxD_start = 1'b1;
            TxD_data  = 8'($urandom);
            step();
         end
         TxD_start = 1'b0;
      end
      run_until_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/async_transmitter.md
# async_transmitter

8N1 UART transmitter that serialises bytes onto the TxD line at a fixed baud rate; the transmit-side counterpart of the design's UART receiver. A small holding FIFO lets the producer queue a burst of bytes, and frames go out back-to-back with no idle gap. It sits between the on-chip byte producer and the TxD pad.

## Interface
Parameters:
- ClkFrequency, 25000000, clk frequency in Hz
- Baud, 115200, line rate in bits/s
- FifoDepth, 4, holding FIFO entries; power of 2, minimum 2

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low; clock clk
- TxD_start  in  1  producer write strobe; byte accepted on a rising edge where TxD_start && TxD_ready
- TxD_data  in  8  byte to send; sampled with TxD_start
- TxD_ready  out  1  FIFO not full
- TxD  out  1  serial line, registered, idle high
- TxD_busy  out  1  FIFO non-empty or frame in progress

## Operation
- BIT_CYCLES = (ClkFrequency + Baud/2) / Baud, integer division. Elaboration error if BIT_CYCLES < 2 or FifoDepth is invalid.
- Bit timer counts 0..BIT_CYCLES-1 and restarts at every state entry. Each line bit lasts exactly BIT_CYCLES clocks.
- FIFO: circular buffer with write/read pointers and a count of width log2(FifoDepth)+1. Pointers wrap modulo FifoDepth.
  - TxD_ready = (count != FifoDepth).
  - Push and pop in the same cycle leaves count unchanged.
  - When full, a push is rejected even if a pop occurs that cycle.
- FSM states:
  - IDLE: TxD=1. If FIFO non-empty: pop into shift register, go to START.
  - START: TxD=0 for BIT_CYCLES, then go to DATA with bit index 0.
  - DATA: TxD=shift[0], LSB first. At the end of each bit, shift right and increment the 3-bit index. After index 7, go to PARITY if enabled, else STOP.
  - PARITY (only with macro): TxD = XOR of the 8 data bits (even parity), then go to STOP.
  - STOP: TxD=1 for BIT_CYCLES. At the end: if FIFO non-empty, pop and go directly to START (no idle bit); else go to IDLE.
- Data is captured at pop. The FIFO slot may be overwritten after the pop.
- TxD_busy = (state != IDLE) || (count != 0).

## Timing
- Reset values: TxD=1, TxD_ready=1, TxD_busy=0, FSM=IDLE, FIFO empty, timer=0.
- Reset asserted mid-frame: on the next edge, TxD=1 and FSM=IDLE; the frame is aborted and FIFO contents are discarded.
- Latency, with an idle FSM and empty FIFO:
  - Push at edge N.
  - Pop at edge N+1; TxD falls after edge N+1.
  - Start bit occupies edges N+1 .. N+BIT_CYCLES.
  - TxD_busy rises after edge N.
- Frame length: 10×BIT_CYCLES clocks (11×BIT_CYCLES with parity).
- TxD_busy falls on the same edge as the IDLE entry that follows the last stop bit.
- TxD_ready updates one edge after the push/pop that changes count.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state is compiled in; frames are 8E1 (even parity bit between bit 7 and stop).
- UART_TX_PARITY_EN undefined: no PARITY state or parity logic; frames are 8N1.

## Test plan
Bench parameters: ClkFrequency=800000, Baud=100000 (BIT_CYCLES=8), FifoDepth=4.
- Single byte: push 0x55 -> TxD sequence 0,1,0,1,0,1,0,1,0,1, each bit 8 clocks (80 clocks total); TxD_busy high for exactly 81 clocks from the push edge.
- Parity build with UART_TX_PARITY_EN: push 0x55 -> parity bit 0; push 0x07 -> parity bit 1; frame is 88 clocks.
- Burst/full: hold TxD_start for 6 consecutive cycles with 0x11..0x16 ->
  - 0x11..0x15 accepted; TxD_ready low after the 5th accept; 0x16 rejected.
  - Five frames sent contiguously (400 clocks), each stop bit followed immediately by the next start bit.
- Push during transmission: push 0xA3 while the 0x3C frame is in its DATA bits -> 0x3C completes unchanged, then 0xA3 starts immediately after the stop bit.
- Reset mid-frame: rst_n low for 1 cycle during bit 4 of 0xF0, with 2 bytes queued -> TxD=1, TxD_busy=0, TxD_ready=1 next edge; nothing further transmitted.
- Idle line: no pushes for 1000 clocks after reset -> TxD constantly 1, TxD_busy=0.
